// File: rtl/data_memory_sync.sv
// Byte-addressed big-endian data memory with a fixed-latency response pipeline.
// After reset the whole array is cleared four bytes per cycle before requests are accepted.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_CLEAR | zeroing memory one word per cycle; busy=1, req_ready=0
//   ST_READY | accepting one request per cycle; busy=0, req_ready=1
module data_memory_sync #(
    parameter int ADDR_W      = 9,
    parameter int READ_LAT    = 1,
    parameter int CHECK_ALIGN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              read_write,
    input  logic [1:0]        size,
    input  logic              se,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic              resp_valid,
    output logic [31:0]       data_out,
    output logic              error,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DEPTH / 4 - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state;
    logic [CNT_W-1:0]  clr_cnt;
    logic [CNT_W-1:0]  clr_word;
    logic [ADDR_W-1:0] clr_base;

    logic [7:0] mem [DEPTH];

    logic              accept;
    logic              misalign;
    logic [ADDR_W-1:0] a1, a2, a3;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       rdata;
    logic [31:0]       resp_d;

    logic [READ_LAT-1:0]       pv;
    logic [READ_LAT-1:0]       pe;
    logic [READ_LAT-1:0][31:0] pd;

    assign req_ready = (state == ST_READY);
    assign busy      = (state == ST_CLEAR);
    assign accept    = req_valid && req_ready;

    // Byte lanes wrap naturally at the address width.
    assign a1 = address + ADDR_W'(1);
    assign a2 = address + ADDR_W'(2);
    assign a3 = address + ADDR_W'(3);

    assign b0 = mem[address];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    assign misalign = (CHECK_ALIGN != 0) &&
                      (((size == 2'b01) && address[0]) ||
                       (size[1] && (address[1:0] != 2'b00)));

    always_comb begin
        rdata = '0;
        case (size)
            2'b00:   rdata = {{24{se & b0[7]}}, b0};
            2'b01:   rdata = {{16{se & b0[7]}}, b0, b1};
            default: rdata = {b0, b1, b2, b3};
        endcase
    end

    assign resp_d = (read_write || misalign) ? 32'h0 : rdata;

    // Down-counter walks words 0..DEPTH/4-1 in ascending order.
    assign clr_word = LAST_WORD - clr_cnt;
    assign clr_base = ADDR_W'({clr_word, 2'b00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= LAST_WORD;
        end else if (state == ST_CLEAR) begin
            if (clr_cnt == '0) begin
                state <= ST_READY;
            end else begin
                clr_cnt <= clr_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            for (int k = 0; k < 4; k++) begin
                mem[clr_base | ADDR_W'(k)] <= 8'h00;
            end
        end else if (accept && read_write && !misalign) begin
            case (size)
                2'b00: begin
                    mem[address] <= data_in[7:0];
                end
                2'b01: begin
                    mem[address] <= data_in[15:8];
                    mem[a1]      <= data_in[7:0];
                end
                default: begin
                    mem[address] <= data_in[31:24];
                    mem[a1]      <= data_in[23:16];
                    mem[a2]      <= data_in[15:8];
                    mem[a3]      <= data_in[7:0];
                end
            endcase
        end
    end

    // Data/error stages load only behind a valid so the outputs hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pe <= '0;
            pd <= '0;
        end else begin
            pv[0] <= accept;
            if (accept) begin
                pd[0] <= resp_d;
                pe[0] <= misalign;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pd[i] <= pd[i-1];
                    pe[i] <= pe[i-1];
                end
            end
        end
    end

    assign resp_valid = pv[READ_LAT-1];
    assign data_out   = pd[READ_LAT-1];
    assign error      = pe[READ_LAT-1];

endmodule

// File: tb/tb_data_memory_sync.sv
// Bench for data_memory_sync: two instances (aligned/latency 3 and unaligned/latency 1)
// share stimulus; a byte-array model feeds per-instance response queues.
module tb_data_memory_sync;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        read_write = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        se = 1'b0;
    logic [8:0]  address = '0;
    logic [31:0] data_in = '0;

    logic        ready_a, rv_a, err_a, busy_a;
    logic [31:0] do_a;
    logic        ready_b, rv_b, err_b, busy_b;
    logic [31:0] do_b;

    data_memory_sync #(.ADDR_W(9), .READ_LAT(3), .CHECK_ALIGN(1)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
        .read_write(read_write), .size(size), .se(se), .address(address),
        .data_in(data_in), .resp_valid(rv_a), .data_out(do_a), .error(err_a),
        .busy(busy_a));

    data_memory_sync #(.ADDR_W(9), .READ_LAT(1), .CHECK_ALIGN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b),
        .read_write(read_write), .size(size), .se(se), .address(address),
        .data_in(data_in), .resp_valid(rv_b), .data_out(do_b), .error(err_b),
        .busy(busy_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    logic [7:0] ma [512];
    logic [7:0] mb [512];

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] last_da = '0, last_db = '0;
    logic        last_ea = 1'b0, last_eb = 1'b0;

    function automatic logic [32:0] model(input bit which, input bit ca, input bit rw,
                                          input logic [1:0] sz, input bit s,
                                          input logic [8:0] a, input logic [31:0] d);
        int n;
        int idx;
        logic [31:0] v;
        if (ca && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00)))
            return {1'b1, 32'h0};
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (rw) begin
            for (int k = 0; k < n; k++) begin
                idx = (int'(a) + k) % 512;
                if (which) mb[idx] = d[8*(n-1-k) +: 8];
                else       ma[idx] = d[8*(n-1-k) +: 8];
            end
            return 33'h0;
        end
        v = '0;
        for (int k = 0; k < n; k++) begin
            idx = (int'(a) + k) % 512;
            v = (v << 8) | {24'h0, (which ? mb[idx] : ma[idx])};
        end
        if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return {1'b0, v};
    endfunction

    // Call at posedge+1; request is accepted at the next posedge.
    task automatic issue(input bit rw, input logic [1:0] sz, input bit s,
                         input logic [8:0] a, input logic [31:0] d,
                         input bit [1:0] pm = 2'b11);
        logic [32:0] r;
        read_write = rw; size = sz; se = s; address = a; data_in = d;
        req_valid = 1'b1;
        @(posedge clk); #1;
        r = model(1'b0, 1'b1, rw, sz, s, a, d);
        if (pm[0]) qa.push_back('{d: r[31:0], e: r[32], c: cyc + 2});
        r = model(1'b1, 1'b0, rw, sz, s, a, d);
        if (pm[1]) qb.push_back('{d: r[31:0], e: r[32], c: cyc});
    endtask

    task automatic idle(input int n = 1);
        req_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            n_checks++;
            if (rv_a) begin
                if (qa.size() == 0) begin
                    $display("FAIL resp_a_unexpected: got data=%h err=%b at cyc %0d, required no response",
                             do_a, err_a, cyc);
                    last_da = do_a; last_ea = err_a;
                end else begin
                    e = qa.pop_front();
                    if (do_a !== e.d || err_a !== e.e || cyc !== e.c)
                        $display("FAIL resp_a: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d",
                                 do_a, err_a, cyc, e.d, e.e, e.c);
                    else n_pass++;
                    last_da = e.d; last_ea = e.e;
                end
            end else if (do_a !== last_da || err_a !== last_ea) begin
                $display("FAIL hold_a: got data=%h err=%b, required data=%h err=%b",
                         do_a, err_a, last_da, last_ea);
            end else n_pass++;

            n_checks++;
            if (rv_b) begin
                if (qb.size() == 0) begin
                    $display("FAIL resp_b_unexpected: got data=%h err=%b at cyc %0d, required no response",
                             do_b, err_b, cyc);
                    last_db = do_b; last_eb = err_b;
                end else begin
                    e = qb.pop_front();
                    if (do_b !== e.d || err_b !== e.e || cyc !== e.c)
                        $display("FAIL resp_b: got data=%h err=%b cyc=%0d, required data=%h err=%b cyc=%0d",
                                 do_b, err_b, cyc, e.d, e.e, e.c);
                    else n_pass++;
                    last_db = e.d; last_eb = e.e;
                end
            end else if (do_b !== last_db || err_b !== last_eb) begin
                $display("FAIL hold_b: got data=%h err=%b, required data=%h err=%b",
                         do_b, err_b, last_db, last_eb);
            end else n_pass++;
        end
    endtask

    task automatic release_and_clear();
        int cnt;
        for (int i = 0; i < 512; i++) begin ma[i] = 8'h00; mb[i] = 8'h00; end
        rst_n = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            if (busy_a) cnt++;
        end while (busy_a && cnt < 1000);
        n_checks++;
        if (cnt !== 128) $display("FAIL busy_cycles: got %0d, required 128", cnt);
        else n_pass++;
        n_checks++;
        if ({ready_a, ready_b, busy_b} !== 3'b110)
            $display("FAIL ready_after_clear: got ready_a=%b ready_b=%b busy_b=%b, required 1 1 0",
                     ready_a, ready_b, busy_b);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rv_a, err_a, ready_a, busy_a} !== 4'b0001 || do_a !== 32'h0)
            $display("FAIL reset_a: got rv=%b err=%b ready=%b busy=%b data=%h, required 0 0 0 1 00000000",
                     rv_a, err_a, ready_a, busy_a, do_a);
        else n_pass++;
        n_checks++;
        if ({rv_b, err_b, ready_b, busy_b} !== 4'b0001 || do_b !== 32'h0)
            $display("FAIL reset_b: got rv=%b err=%b ready=%b busy=%b data=%h, required 0 0 0 1 00000000",
                     rv_b, err_b, ready_b, busy_b, do_b);
        else n_pass++;
        release_and_clear();
        issue(1'b0, 2'b10, 1'b0, 9'h000, 32'h0);
        idle(1);
    endtask

    task automatic test_sign_ext();
        issue(1'b1, 2'b10, 1'b0, 9'h010, 32'h8A5B_3C7D);
        idle(1);
        issue(1'b0, 2'b00, 1'b1, 9'h010, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 9'h012, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 9'h010, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 9'h013, 32'h0);
        issue(1'b0, 2'b11, 1'b1, 9'h010, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 9'h014, 32'h0000_7F80);
        issue(1'b0, 2'b01, 1'b1, 9'h014, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 9'h015, 32'h0);
        idle(4);
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'b00, 1'b0, 9'h021, 32'hFFFF_FFF0);
        issue(1'b0, 2'b10, 1'b0, 9'h020, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 9'h021, 32'h0);
        idle(4);
    endtask

    task automatic test_misalign();
        issue(1'b1, 2'b10, 1'b0, 9'h006, 32'hDEAD_BEEF);
        issue(1'b0, 2'b10, 1'b0, 9'h004, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 9'h008, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 9'h011, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 9'h1FE, 32'h1122_3344);
        issue(1'b0, 2'b00, 1'b0, 9'h1FE, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 9'h1FF, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 9'h001, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 9'h1FF, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 9'h031, 32'h0000_ABCD);
        issue(1'b0, 2'b10, 1'b0, 9'h030, 32'h0);
        idle(4);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  9'($urandom_range(0, 511)), $urandom);
        end
        idle(4);
    endtask

    task automatic test_reset_inflight();
        issue(1'b1, 2'b10, 1'b0, 9'h040, 32'hCAFE_F00D);
        idle(3);
        issue(1'b0, 2'b10, 1'b0, 9'h040, 32'h0, 2'b10);
        issue(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 2'b00);
        req_valid = 1'b0;
        rst_n = 1'b0;
        last_da = '0; last_ea = 1'b0; last_db = '0; last_eb = 1'b0;
        #1;
        n_checks++;
        if ({rv_a, err_a, ready_a, busy_a} !== 4'b0001 || do_a !== 32'h0)
            $display("FAIL reset_inflight_a: got rv=%b err=%b ready=%b busy=%b data=%h, required 0 0 0 1 00000000",
                     rv_a, err_a, ready_a, busy_a, do_a);
        else n_pass++;
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0)
            $display("FAIL reset_queue: got %0d/%0d pending, required 0/0", qa.size(), qb.size());
        else n_pass++;
        qa.delete(); qb.delete();
        repeat (5) @(posedge clk);
        #1;
        release_and_clear();
        for (int i = 0; i < 128; i++) issue(1'b0, 2'b10, 1'b0, 9'(4 * i), 32'h0);
        idle(4);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_sign_ext();
        test_back_to_back();
        test_misalign();
        test_random();
        test_reset_inflight();
        idle(6);
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0)
            $display("FAIL drain: got %0d/%0d responses missing, required 0/0", qa.size(), qb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory_sync.md
DATA_MEMORY_SYNC -- requirements
Module: data_memory_sync

Interface
REQ-001 Parameter ADDR_W, default 9, byte-address width; byte capacity DEPTH = 2**ADDR_W; ADDR_W SHALL be >= 2.
REQ-002 Parameter READ_LAT, default 1, request-to-response latency in cycles; legal values 1..4.
REQ-003 Parameter CHECK_ALIGN, default 1; 1 enables the misalignment error, 0 allows unaligned access.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 ReqValid  input  1  request present this cycle.
REQ-007 ReqReady  output  1  block can accept a request; request accepted when ReqValid && ReqReady at a rising edge.
REQ-008 ReadWrite  input  1  1 = write, 0 = read.
REQ-009 Size  input  2  00 byte, 01 halfword, 10 word, 11 word alias.
REQ-010 SE  input  1  sign-extend byte/halfword reads.
REQ-011 Address  input  ADDR_W  byte address of the most significant byte (big-endian).
REQ-012 DataIn  input  32  write data; byte in [7:0], halfword in [15:0], word in [31:0].
REQ-013 RespValid  output  1  one-cycle pulse, one per accepted request.
REQ-014 DataOut  output  32  read result, qualified by RespValid.
REQ-015 Error  output  1  misalignment flag, qualified by RespValid.
REQ-016 Busy  output  1  high while the clear sequence runs.

Function
REQ-017 Storage SHALL be DEPTH bytes, big-endian: Mem[A] = MSB, Mem[A+1] next, and so on.
REQ-018 Two-state FSM: CLEAR -> READY. CLEAR writes zero to 4 bytes per cycle for DEPTH/4 cycles, then moves to READY. Busy=1 and ReqReady=0 in CLEAR; Busy=0 and ReqReady=1 in READY.
REQ-019 Up to one request SHALL be accepted per cycle, with no stall while in READY.
REQ-020 Write: bytes SHALL be updated at the acceptance edge. Byte -> Mem[A]=DataIn[7:0]. Half -> Mem[A]=DataIn[15:8], Mem[A+1]=DataIn[7:0]. Word -> DataIn[31:24..7:0] into Mem[A..A+3].
REQ-021 Read: data SHALL be sampled at the acceptance edge and returned on DataOut with RespValid exactly READ_LAT cycles after acceptance.
REQ-022 Byte/halfword reads with SE=0 SHALL zero-extend; with SE=1 they SHALL replicate bit 7 (byte) or bit 15 (halfword) of the result into all upper bits. SE SHALL be ignored for Size 10/11.
REQ-023 Every accepted write SHALL produce RespValid after READ_LAT cycles with DataOut=0 and Error=0. Responses SHALL be returned in acceptance order.
REQ-024 Misalignment (CHECK_ALIGN=1): a halfword with A[0]!=0 or a word with A[1:0]!=0 is misaligned. Memory SHALL be left unchanged, the response SHALL carry Error=1, and DataOut SHALL be 0.
REQ-025 With CHECK_ALIGN=0, byte addresses A+k SHALL wrap modulo DEPTH, and Error SHALL stay 0.
REQ-026 A read accepted the cycle after a write to the same bytes SHALL return the new data.
REQ-027 Outside of RespValid, DataOut and Error SHALL hold their last values; RespValid SHALL be 0.

Reset
REQ-028 Reset_n low SHALL immediately force RespValid=0, Error=0, DataOut=0, ReqReady=0, Busy=1, flush the response pipeline, and place the FSM in CLEAR.
REQ-029 Asserting reset mid-operation SHALL drop in-flight responses. Clearing SHALL restart from byte 0 after Reset_n deasserts.
REQ-030 Memory contents are defined only after CLEAR completes, and SHALL then be all zero.

Verification
REQ-031 Release reset, ADDR_W=9 -> Busy high for 128 cycles, then ReqReady=1; a word read at 0x000 returns 0x00000000.
REQ-032 Write word 0x8A5B3C7D @0x010, then read byte @0x010 with SE=1 -> 0xFFFFFF8A; read half @0x012 with SE=0 -> 0x00003C7D; READ_LAT=3 -> RespValid exactly 3 cycles after each acceptance.
REQ-033 Back-to-back: write byte 0xF0 @0x021, then read word @0x020 on the next cycle -> 0x00F0xxxx, with the byte at 0x021 updated; responses arrive in order on consecutive cycles.
REQ-034 CHECK_ALIGN=1, word write @0x006 -> Error=1 and memory unchanged; CHECK_ALIGN=0, word write 0x11223344 @0x1FE -> 0x1FE=11, 0x1FF=22, 0x000=33, 0x001=44.
REQ-035 Assert Reset_n low while 2 reads are in flight -> no RespValid pulses; CLEAR reruns in full, and all locations read 0 afterwards.
